// File: rtl/gfx_pkg.sv
// gfx_pkg: shared raster-op encoding, RMW FSM states and strip mask helpers
// range_mask(lo, hi, sw): bits lo..hi set, both ends clipped to sw-1
// clip(idx, sw): index limited to sw-1
package gfx_pkg;
  typedef enum logic [1:0] {ROP_COPY, ROP_AND, ROP_OR, ROP_XOR} rop_e;
  typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_e;
  localparam int MAX_SW = 256;
  function automatic int clip(input int idx, input int sw);
    return idx > sw - 1 ? sw - 1 : idx;
  endfunction
  function automatic logic [MAX_SW-1:0] range_mask(input int lo, input int hi, input int sw);
    logic [MAX_SW-1:0] m;
    int l;
    int h;
    l = clip(lo, sw);
    h = clip(hi, sw);
    for (int i = 0; i < MAX_SW; i++) m[i] = i >= l && i <= h;
    return m;
  endfunction
endpackage

// File: rtl/gfx_bit_merge.sv
// gfx_bit_merge: combinational pixel merge of a colour into one memory strip
// old: strip read from memory; color: right-justified pixel colour
// mb/me/ce: mask begin, mask end, colour-bits end; rop: raster op
// new_strip: old strip with bits mb..min(ce,me) replaced by rop(color, old)
module gfx_bit_merge
  import gfx_pkg::*;
#(
  parameter int SW = 128,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic [SW-1:0] old,
  input  logic [31:0]   color,
  input  logic [BN:0]   mb,
  input  logic [BN:0]   me,
  input  logic [BN:0]   ce,
  input  rop_e          rop,
  output logic [SW-1:0] new_strip
);
  logic [SW-1:0] col;
  logic [SW-1:0] sh;
  logic [SW-1:0] r;
  always_comb begin
    col = SW'(range_mask(int'(mb), int'(me), SW)) & SW'(range_mask(int'(mb), int'(ce), SW));
    sh = SW'(color) << clip(int'(mb), SW);
    r = rop == ROP_COPY ? sh : rop == ROP_AND ? sh & old : rop == ROP_OR ? sh | old : sh ^ old;
    new_strip = (col & r) | (~col & old);
  end
endmodule

// File: rtl/gfx_pixel_rmw.sv
// gfx_pixel_rmw: read-modify-write of one pixel inside a memory strip
// req_i/rdy_o: request handshake; address_i, mb_i, me_i, ce_i, color_i, rop_i: pixel command
// done_o: one-cycle completion pulse
// mem_*: single-master memory bus (cyc/we/adr/sel/dat out, ack/dat in)
module gfx_pixel_rmw
  import gfx_pkg::*;
#(
  parameter int SW = 128,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  output logic            rdy_o,
  input  logic [31:0]     address_i,
  input  logic [BN:0]     mb_i,
  input  logic [BN:0]     me_i,
  input  logic [BN:0]     ce_i,
  input  logic [31:0]     color_i,
  input  logic [1:0]      rop_i,
  output logic            done_o,
  output logic            mem_cyc_o,
  output logic            mem_we_o,
  output logic [31:0]     mem_adr_o,
  output logic [SW/8-1:0] mem_sel_o,
  output logic [SW-1:0]   mem_dat_o,
  input  logic            mem_ack_i,
  input  logic [SW-1:0]   mem_dat_i
);
  state_e state;
  state_e state_n;
  logic [31:BN-2] adr_q;
  logic [BN:0] mb_q;
  logic [BN:0] me_q;
  logic [BN:0] ce_q;
  logic [31:0] color_q;
  rop_e rop_q;
  logic [SW-1:0] old_q;
  logic [SW-1:0] new_q;
  logic [SW-1:0] merged;
  logic [SW-1:0] wmask;
  logic [SW/8-1:0] wsel;
  logic unused_addr;
  // the low address bits only select a byte inside the strip, which the masks already encode
  assign unused_addr = ^address_i[BN-3:0];
  assign wmask = SW'(range_mask(int'(mb_q), int'(me_q), SW));
  for (genvar b = 0; b < SW / 8; b++) begin : g_sel
    assign wsel[b] = |wmask[8*b+:8];
  end
  gfx_bit_merge #(.SW(SW), .BN(BN)) u_merge (
    .old(old_q),
    .color(color_q),
    .mb(mb_q),
    .me(me_q),
    .ce(ce_q),
    .rop(rop_q),
    .new_strip(merged)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (req_i ? RD : IDLE) :
              state == RD   ? (mem_ack_i ? MRG : RD) :
              state == MRG  ? WR :
                              (mem_ack_i ? IDLE : WR);
    rdy_o = state == IDLE;
    mem_cyc_o = state == RD || state == WR;
    mem_we_o = state == WR;
    mem_adr_o = mem_cyc_o ? {adr_q, {(BN - 2){1'b0}}} : '0;
    mem_sel_o = state == RD ? '1 : state == WR ? wsel : '0;
    mem_dat_o = state == WR ? new_q : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done_o <= 1'b0;
      adr_q <= '0;
      mb_q <= '0;
      me_q <= '0;
      ce_q <= '0;
      color_q <= '0;
      rop_q <= ROP_COPY;
      old_q <= '0;
      new_q <= '0;
    end else begin
      done_o <= state == WR && mem_ack_i;
      if (state == IDLE && req_i) begin
        adr_q <= address_i[31:BN-2];
        mb_q <= mb_i;
        me_q <= me_i;
        ce_q <= ce_i;
        color_q <= color_i;
        rop_q <= rop_e'(rop_i);
      end
      if (state == RD && mem_ack_i) old_q <= mem_dat_i;
      if (state == MRG) new_q <= merged;
    end
endmodule

// File: tb/tb_gfx_pixel_rmw.sv
// tb_gfx_pixel_rmw: scoreboard bench for gfx_pixel_rmw (8-bit mask indices so clipping is reachable)
module tb_gfx_pixel_rmw;
  localparam int SW = 128;
  localparam int BN = 7;
  localparam int SB = SW / 8;
  typedef struct {
    logic [31:0]   adr;
    logic [SB-1:0] sel;
    logic [SW-1:0] dat;
  } wr_t;
  logic clk = 0;
  logic rst = 1;
  logic req_i = 0;
  logic rdy_o;
  logic [31:0] address_i = 0;
  logic [BN:0] mb_i = 0;
  logic [BN:0] me_i = 0;
  logic [BN:0] ce_i = 0;
  logic [31:0] color_i = 0;
  logic [1:0] rop_i = 0;
  logic done_o;
  logic mem_cyc_o;
  logic mem_we_o;
  logic [31:0] mem_adr_o;
  logic [SB-1:0] mem_sel_o;
  logic [SW-1:0] mem_dat_o;
  logic mem_ack_i = 0;
  logic [SW-1:0] mem_dat_i;
  logic [SW-1:0] rd_data = '0;
  logic stray = 0;
  int tests = 0;
  int fails = 0;
  int pc = 0;
  int done_cnt = 0;
  int rd_wait = 0;
  int wr_wait = 0;
  wr_t exp_q[$];

  assign mem_dat_i = rd_data;
  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;
  always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

  gfx_pixel_rmw #(.SW(SW), .BN(BN)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rdy_o(rdy_o), .address_i(address_i),
    .mb_i(mb_i), .me_i(me_i), .ce_i(ce_i), .color_i(color_i), .rop_i(rop_i),
    .done_o(done_o), .mem_cyc_o(mem_cyc_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  // bus slave: acks after rd_wait/wr_wait wait cycles, checks read and write phases against the scoreboard
  initial begin
    int cnt;
    wr_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_cyc_o) begin
        cnt = 0;
        mem_ack_i = stray && !rst;
      end else begin
        mem_ack_i = cnt == (mem_we_o ? wr_wait : rd_wait);
        cnt++;
        if (mem_ack_i) begin
          cnt = 0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL bus_unexpected: cycle with we=%0b adr=%h, no transaction expected", mem_we_o, mem_adr_o);
          end else if (!mem_we_o) begin
            if (mem_adr_o !== exp_q[0].adr || mem_sel_o !== {SB{1'b1}}) begin
              fails++;
              $display("FAIL read_phase: adr=%h sel=%h, want adr=%h sel=ffff", mem_adr_o, mem_sel_o, exp_q[0].adr);
            end
          end else begin
            e = exp_q.pop_front();
            if (mem_adr_o !== e.adr || mem_sel_o !== e.sel || mem_dat_o !== e.dat) begin
              fails++;
              $display("FAIL write_phase: adr=%h sel=%h dat=%h, want adr=%h sel=%h dat=%h",
                       mem_adr_o, mem_sel_o, mem_dat_o, e.adr, e.sel, e.dat);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] strip_adr(input logic [31:0] a);
    return a & ~((32'd1 << (BN - 2)) - 1);
  endfunction

  function automatic wr_t model(input logic [31:0] a, input int mb, input int me, input int ce,
                                input logic [31:0] c, input logic [1:0] r, input logic [SW-1:0] old);
    wr_t m;
    int lo;
    int hi;
    int ch;
    logic cb;
    lo = mb > SW - 1 ? SW - 1 : mb;
    hi = me > SW - 1 ? SW - 1 : me;
    ch = ce > SW - 1 ? SW - 1 : ce;
    m.adr = strip_adr(a);
    m.sel = '0;
    m.dat = old;
    for (int i = 0; i < SW; i++)
      if (i >= lo && i <= hi) begin
        m.sel[i/8] = 1'b1;
        if (i <= ch) begin
          cb = (i - lo) < 32 ? c[i-lo] : 1'b0;
          case (r)
            2'd0: m.dat[i] = cb;
            2'd1: m.dat[i] = cb & old[i];
            2'd2: m.dat[i] = cb | old[i];
            default: m.dat[i] = cb ^ old[i];
          endcase
        end
      end
    return m;
  endfunction

  task automatic issue(input logic [31:0] a, input int mb, input int me, input int ce,
                       input logic [31:0] c, input logic [1:0] r, input bit hold, output int acc);
    @(negedge clk);
    for (int k = 0; k < 50 && !rdy_o; k++) @(negedge clk);
    tests++;
    if (!rdy_o) begin
      fails++;
      $display("FAIL issue_rdy: rdy_o=%0b, want 1 within 50 cycles", rdy_o);
    end
    address_i = a;
    mb_i = (BN + 1)'(mb);
    me_i = (BN + 1)'(me);
    ce_i = (BN + 1)'(ce);
    color_i = c;
    rop_i = r;
    req_i = 1;
    acc = pc;
    @(negedge clk);
    if (!hold) req_i = 0;
  endtask

  task automatic wait_done(input int acc, input int lat, input int ncyc, input string nm);
    int nc;
    int nr;
    bit got;
    nc = 0;
    nr = 0;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_o) begin
        got = 1;
        break;
      end
      if (mem_cyc_o) nc++;
      if (rdy_o) nr++;
      @(negedge clk);
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_done: no done_o within 60 cycles, want latency %0d", nm, lat);
    end else begin
      tests += 4;
      if (pc - acc !== lat) begin
        fails++;
        $display("FAIL %s_latency: %0d cycles, want %0d", nm, pc - acc, lat);
      end
      if (nc !== ncyc) begin
        fails++;
        $display("FAIL %s_cyc_cycles: %0d, want %0d", nm, nc, ncyc);
      end
      if (nr !== 0) begin
        fails++;
        $display("FAIL %s_rdy_busy: rdy_o high %0d cycles while busy, want 0", nm, nr);
      end
      if (rdy_o !== 1'b1) begin
        fails++;
        $display("FAIL %s_rdy_at_done: rdy_o=%0b, want 1", nm, rdy_o);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    tests++;
    if ({rdy_o, mem_cyc_o, mem_we_o, done_o} !== 4'b1000 || mem_sel_o !== '0 || mem_adr_o !== '0 || mem_dat_o !== '0) begin
      fails++;
      $display("FAIL %s: rdy/cyc/we/done=%b sel=%h adr=%h dat=%h, want 1000 and zeros",
               nm, {rdy_o, mem_cyc_o, mem_we_o, done_o}, mem_sel_o, mem_adr_o, mem_dat_o);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_copy();
    int acc;
    rd_data = '0;
    exp_q.push_back('{32'h0000_1040, 16'h000C, 128'h1234_0000});
    issue(32'h0000_105C, 16, 31, 31, 32'h1234, 2'd0, 0, acc);
    wait_done(acc, 4, 2, "copy");
  endtask

  task automatic test_xor();
    int acc;
    rd_data = '1;
    exp_q.push_back('{32'h0000_2000, 16'hF000, {2'b11, 30'h0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF}});
    issue(32'h0000_2000, 96, 127, 125, 32'h3FFF_FFFF, 2'd3, 0, acc);
    wait_done(acc, 4, 2, "xor");
  endtask

  task automatic test_random_ops();
    int acc;
    int mb;
    int me;
    int ce;
    logic [31:0] a;
    logic [31:0] c;
    logic [1:0] r;
    for (int n = 0; n < 8; n++) begin
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      a = $urandom;
      c = $urandom;
      r = 2'(n);
      mb = $urandom_range(0, 140);
      me = $urandom_range(0, 160);
      ce = $urandom_range(0, 160);
      exp_q.push_back(model(a, mb, me, ce, c, r, rd_data));
      issue(a, mb, me, ce, c, r, 0, acc);
      wait_done(acc, 4, 2, "random");
    end
  endtask

  task automatic test_waits();
    int acc;
    rd_wait = 3;
    wr_wait = 2;
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(32'h0000_3020, 40, 71, 63, 32'h00AB_CDEF, 2'd2, rd_data));
    issue(32'h0000_3020, 40, 71, 63, 32'h00AB_CDEF, 2'd2, 0, acc);
    wait_done(acc, 9, 7, "waits");
    rd_wait = 0;
    wr_wait = 0;
  endtask

  task automatic test_clip();
    int acc;
    rd_data = '0;
    exp_q.push_back('{32'h0000_4000, 16'h8000, {8'hA5, 120'h0}});
    issue(32'h0000_4000, 120, 135, 135, 32'h0000_00A5, 2'd0, 0, acc);
    wait_done(acc, 4, 2, "clip");
  endtask

  task automatic test_empty_mask();
    int acc;
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back('{32'h0000_5000, 16'h0000, rd_data});
    issue(32'h0000_5000, 50, 40, 60, 32'hFFFF_FFFF, 2'd0, 0, acc);
    wait_done(acc, 4, 2, "empty_mask");
  endtask

  task automatic test_stray_ack();
    int acc;
    stray = 1;
    repeat (3) @(negedge clk);
    check_idle_outputs("stray_ack_idle");
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(32'h0000_6000, 8, 23, 23, 32'h0000_5A5A, 2'd1, rd_data));
    issue(32'h0000_6000, 8, 23, 23, 32'h0000_5A5A, 2'd1, 0, acc);
    wait_done(acc, 4, 2, "stray_ack");
    @(negedge clk);
    check_idle_outputs("stray_ack_after");
    stray = 0;
  endtask

  task automatic test_reset_mid();
    int acc;
    int d0;
    bit seen;
    wr_wait = 5;
    rd_data = '0;
    exp_q.push_back(model(32'h0000_7000, 0, 31, 31, 32'hDEAD_BEEF, 2'd0, rd_data));
    issue(32'h0000_7000, 0, 31, 31, 32'hDEAD_BEEF, 2'd0, 0, acc);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_we_o) seen = 1;
      else @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL reset_mid_reach_wr: mem_we_o=%0b, want 1 within 20 cycles", mem_we_o);
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    tests++;
    if (mem_cyc_o !== 1'b0 || mem_we_o !== 1'b0 || rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_async: cyc=%0b we=%0b rdy=%0b, want 0 0 1", mem_cyc_o, mem_we_o, rdy_o);
    end
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    wr_wait = 0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL reset_mid_no_done: %0d done pulses after abort, want 0", done_cnt - d0);
    end
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(32'h0000_7400, 64, 95, 87, 32'h00C0_FFEE, 2'd3, rd_data));
    issue(32'h0000_7400, 64, 95, 87, 32'h00C0_FFEE, 2'd3, 0, acc);
    wait_done(acc, 4, 2, "reset_mid_next");
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    rd_data = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(32'h0000_8000, 0, 15, 15, 32'h0000_BEEF, 2'd0, rd_data));
    issue(32'h0000_8000, 0, 15, 15, 32'h0000_BEEF, 2'd0, 1, acc1);
    address_i = 32'h0000_8100;
    mb_i = 8'd32;
    me_i = 8'd63;
    ce_i = 8'd55;
    color_i = 32'h0012_3456;
    rop_i = 2'd2;
    exp_q.push_back(model(32'h0000_8100, 32, 63, 55, 32'h0012_3456, 2'd2, rd_data));
    wait_done(acc1, 4, 2, "b2b_first");
    acc2 = pc;
    @(negedge clk);
    req_i = 0;
    wait_done(acc2, 4, 2, "b2b_second");
    @(negedge clk);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL b2b_drained: %0d writes outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_xor();
    test_random_ops();
    test_waits();
    test_clip();
    test_empty_mask();
    test_stray_ack();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
